// File: rtl/vec_hadamard_arbiter.sv
`default_nettype none
// ============================================================================
// vec_hadamard_arbiter : round-robin share of one Hadamard-product unit
// Rev 1.0
// ============================================================================
module vec_hadamard_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int VECTOR_LEN     = 4,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req,
  input  logic [NUM_REQ*VECTOR_LEN*DATA_W-1:0] req_vec1,
  input  logic [NUM_REQ*VECTOR_LEN*DATA_W-1:0] req_vec2,
  output logic [NUM_REQ-1:0]                   grant,
  output logic                                 busy,
  output logic                                 resp_valid,
  output logic [$clog2(NUM_REQ)-1:0]           resp_id,
  output logic                                 resp_err,
  output logic [VECTOR_LEN*DATA_W-1:0]         resp_data,
  output logic                                 hp_rst,
  output logic [VECTOR_LEN*DATA_W-1:0]         hp_vec1,
  output logic [VECTOR_LEN*DATA_W-1:0]         hp_vec2,
  input  logic                                 hp_done,
  input  logic [VECTOR_LEN*DATA_W-1:0]         hp_result
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int VEC_W = VECTOR_LEN * DATA_W;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LATCH = 2'd1,
    S_RUN   = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               busy_q;
  logic               resp_valid_q;
  logic [ID_W-1:0]    resp_id_q;
  logic               resp_err_q;
  logic [VEC_W-1:0]   resp_data_q;
  logic               hp_rst_q;
  logic [VEC_W-1:0]   hp_vec1_q;
  logic [VEC_W-1:0]   hp_vec2_q;
  logic [TMR_W-1:0]   timer_q;
  logic [ID_W-1:0]    last_q;

  logic               found_d;
  logic [ID_W-1:0]    winner_d;
  logic [ID_W:0]      rr_sum;
  logic [ID_W-1:0]    rr_idx;

  // Search starts one past the previous winner and wraps, giving rotation.
  always_comb begin
    found_d  = 1'b0;
    winner_d = '0;
    rr_sum   = '0;
    rr_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      rr_sum = {1'b0, last_q} + (ID_W+1)'(i);
      if (rr_sum >= (ID_W+1)'(NUM_REQ)) begin
        rr_sum = rr_sum - (ID_W+1)'(NUM_REQ);
      end
      rr_idx = rr_sum[ID_W-1:0];
      if (!found_d && req[rr_idx]) begin
        found_d  = 1'b1;
        winner_d = rr_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      hp_rst_q     <= 1'b1;
      hp_vec1_q    <= '0;
      hp_vec2_q    <= '0;
      timer_q      <= '0;
      last_q       <= ID_W'(NUM_REQ - 1);
    end else begin
      grant_q      <= '0;
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          hp_rst_q <= 1'b1;
          if (found_d) begin
            state_q   <= S_LATCH;
            busy_q    <= 1'b1;
            grant_q   <= NUM_REQ'(1) << winner_d;
            hp_vec1_q <= req_vec1[winner_d*VEC_W +: VEC_W];
            hp_vec2_q <= req_vec2[winner_d*VEC_W +: VEC_W];
            last_q    <= winner_d;
            resp_id_q <= winner_d;
          end
        end
        // Unit stays in reset one cycle with stable operands before release.
        S_LATCH: begin
          state_q  <= S_RUN;
          hp_rst_q <= 1'b0;
          timer_q  <= '0;
        end
        S_RUN: begin
          if (hp_done) begin
            resp_data_q  <= hp_result;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            hp_rst_q     <= 1'b1;
            state_q      <= S_RESP;
          end else if (timer_q == TMR_LAST) begin
            resp_data_q  <= '0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            hp_rst_q     <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          hp_rst_q <= 1'b1;
        end
      endcase
    end
  end

  assign grant      = grant_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_err   = resp_err_q;
  assign resp_data  = resp_data_q;
  assign hp_rst     = hp_rst_q;
  assign hp_vec1    = hp_vec1_q;
  assign hp_vec2    = hp_vec2_q;

endmodule
`default_nettype wire

// File: tb/tb_vec_hadamard_arbiter.sv
`default_nettype none
// ============================================================================
// tb_vec_hadamard_arbiter : scoreboard bench with a behavioural fp32 unit stub
// Rev 1.0
// ============================================================================
module tb_vec_hadamard_arbiter;

  localparam int NR   = 2;
  localparam int VL   = 4;
  localparam int DW   = 32;
  localparam int TO   = 64;
  localparam int VW   = VL * DW;
  localparam int ULAT = 3;

  localparam logic [VW-1:0] A0 = {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
  localparam logic [VW-1:0] B0 = {32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
  localparam logic [VW-1:0] P0 = {32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
  localparam logic [VW-1:0] A1 = {32'h40400000, 32'h3F000000, 32'hBF800000, 32'h3FC00000};
  localparam logic [VW-1:0] B1 = {32'h40000000, 32'h40800000, 32'h40000000, 32'h3FC00000};
  localparam logic [VW-1:0] P1 = {32'h40C00000, 32'h40000000, 32'hC0000000, 32'h40100000};
  localparam logic [VW-1:0] A5 = {32'h3FC00000, 32'h40000000, 32'h3F000000, 32'h40400000};
  localparam logic [VW-1:0] B5 = {32'h40400000, 32'h40000000, 32'h3FC00000, 32'h40800000};
  localparam logic [VW-1:0] P5 = {32'h40900000, 32'h40800000, 32'h3F400000, 32'h41400000};
  localparam logic [VW-1:0] JUNK = {4{32'h41200000}};

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR*VW-1:0]  req_vec1 = '0;
  logic [NR*VW-1:0]  req_vec2 = '0;
  logic [NR-1:0]     grant;
  logic              busy, resp_valid, resp_err, hp_rst;
  logic [0:0]        resp_id;
  logic [VW-1:0]     resp_data, hp_vec1, hp_vec2;
  logic              hp_done = 1'b0;
  logic [VW-1:0]     hp_result = '0;
  logic              stub_hang = 1'b0;
  int                ucnt = 0;

  int checks = 0;
  int failures = 0;
  int run_cnt = 0;
  int last_run = 0;

  typedef struct {
    logic [0:0]    id;
    logic          err;
    logic [VW-1:0] data;
  } resp_t;
  resp_t exp_resp[$];
  int    exp_grant[$];

  vec_hadamard_arbiter #(
    .NUM_REQ(NR), .VECTOR_LEN(VL), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_vec1(req_vec1), .req_vec2(req_vec2),
    .grant(grant), .busy(busy), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_err(resp_err), .resp_data(resp_data), .hp_rst(hp_rst),
    .hp_vec1(hp_vec1), .hp_vec2(hp_vec2), .hp_done(hp_done), .hp_result(hp_result)
  );

  always #5 clk = ~clk;

  // Truncating fp32 multiply, exact for the small operands used here.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    int e;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'd0};
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      e = e + 1;
      p = p >> 1;
    end
    return {a[31] ^ b[31], e[7:0], p[45:23]};
  endfunction

  function automatic logic [VW-1:0] hmul(input logic [VW-1:0] x, input logic [VW-1:0] y);
    logic [VW-1:0] r;
    for (int k = 0; k < VL; k++) r[k*DW +: DW] = fmul(x[k*DW +: DW], y[k*DW +: DW]);
    return r;
  endfunction

  always @(posedge clk) begin
    if (hp_rst) begin
      ucnt    <= 0;
      hp_done <= 1'b0;
    end else if (!stub_hang) begin
      ucnt <= ucnt + 1;
      if (ucnt == ULAT - 1) begin
        hp_done   <= 1'b1;
        hp_result <= hmul(hp_vec1, hp_vec2);
      end
    end
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int id, input logic err, input logic [VW-1:0] data, input bit with_resp);
    resp_t r;
    exp_grant.push_back(id);
    if (with_resp) begin
      r.id = 1'(id);
      r.err = err;
      r.data = data;
      exp_resp.push_back(r);
    end
  endtask

  task automatic wait_grant(output int g);
    g = -1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (grant != '0) begin
        g = grant[1] ? 1 : 0;
        break;
      end
    end
    if (g < 0) begin
      checks++; failures++;
      $display("FAIL grant_timeout: got none expected a grant within 200 cycles");
    end else begin
      req[g] = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int c;
    for (c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (!busy) break;
    end
    if (c == 300) begin
      checks++; failures++;
      $display("FAIL idle_timeout: busy still %b after 300 cycles", busy);
    end
  endtask

  task automatic wait_run();
    int c;
    for (c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (!hp_rst) break;
    end
    if (c == 50) begin
      checks++; failures++;
      $display("FAIL run_timeout: hp_rst still %b after 50 cycles", hp_rst);
    end
  endtask

  // Monitor: every grant and response is matched against the scoreboard.
  initial begin
    resp_t r;
    int g;
    forever begin
      @(negedge clk);
      if (!rst) begin
        run_cnt = 0;
      end else begin
        if (!hp_rst) run_cnt++;
        if (grant != '0) begin
          if (exp_grant.size() == 0) begin
            check("grant_unexpected", 160'(grant), 160'(0));
          end else begin
            g = exp_grant.pop_front();
            check("grant", 160'(grant), 160'(2'b01 << g));
          end
        end
        if (resp_valid) begin
          last_run = run_cnt;
          run_cnt = 0;
          if (exp_resp.size() == 0) begin
            check("resp_unexpected", 160'(resp_valid), 160'(0));
          end else begin
            r = exp_resp.pop_front();
            check("resp", 160'({resp_id, resp_err, resp_data}), 160'({r.id, r.err, r.data}));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    req_vec1 = {A1, A0};
    req_vec2 = {B1, B0};
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", 160'(grant), 160'(0));
    check("rst_busy", 160'(busy), 160'(0));
    check("rst_resp_valid", 160'(resp_valid), 160'(0));
    check("rst_resp_err", 160'(resp_err), 160'(0));
    check("rst_resp_id", 160'(resp_id), 160'(0));
    check("rst_resp_data", 160'(resp_data), 160'(0));
    check("rst_hp_rst", 160'(hp_rst), 160'(1));
    check("rst_hp_vec1", 160'(hp_vec1), 160'(0));
    check("rst_hp_vec2", 160'(hp_vec2), 160'(0));
    rst = 1'b1;
    @(posedge clk); #1;

    // contention: both at once, requester 0 first after reset
    push(0, 1'b0, P0, 1'b1);
    push(1, 1'b0, P1, 1'b1);
    req = 2'b11;
    wait_grant(g);
    wait_grant(g);
    wait_idle();

    // fairness: both held high for six grants
    for (int n = 0; n < 6; n++) push(n % 2, 1'b0, (n % 2 == 0) ? P0 : P1, 1'b1);
    req = 2'b11;
    for (int n = 0; n < 6; n++) begin
      wait_grant(g);
      req = 2'b11;
    end
    req = 2'b00;
    wait_idle();

    // single request from requester 0
    push(0, 1'b0, P0, 1'b1);
    req = 2'b01;
    wait_grant(g);
    wait_idle();

    // operand change after grant must not reach the unit
    req_vec1[VW +: VW] = A5;
    req_vec2[VW +: VW] = B5;
    push(1, 1'b0, P5, 1'b1);
    req = 2'b10;
    wait_grant(g);
    req_vec1[VW +: VW] = JUNK;
    wait_run();
    check("latched_vec1_run0", 160'(hp_vec1), 160'(A5));
    @(posedge clk); #1;
    check("latched_vec1_run1", 160'(hp_vec1), 160'(A5));
    check("latched_vec2_run1", 160'(hp_vec2), 160'(B5));
    wait_idle();
    req_vec1[VW +: VW] = A1;
    req_vec2[VW +: VW] = B1;

    // timeout: unit never finishes, then a normal op succeeds
    stub_hang = 1'b1;
    push(0, 1'b1, '0, 1'b1);
    req = 2'b01;
    wait_grant(g);
    wait_idle();
    check("timeout_run_cycles", 160'(last_run), 160'(TO));
    stub_hang = 1'b0;
    push(1, 1'b0, P1, 1'b1);
    req = 2'b10;
    wait_grant(g);
    wait_idle();

    // reset in the middle of RUN: op discarded, priority back to requester 0
    push(0, 1'b0, P0, 1'b0);
    req = 2'b01;
    wait_grant(g);
    wait_run();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mid_rst_hp_rst", 160'(hp_rst), 160'(1));
    check("mid_rst_busy", 160'(busy), 160'(0));
    check("mid_rst_resp_data", 160'(resp_data), 160'(0));
    check("mid_rst_resp_id", 160'(resp_id), 160'(0));
    check("mid_rst_hp_vec1", 160'(hp_vec1), 160'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    push(0, 1'b0, P0, 1'b1);
    req = 2'b11;
    wait_grant(g);
    req = 2'b00;
    wait_idle();
    repeat (5) @(posedge clk);
    #1;

    check("sb_grants_left", 160'(exp_grant.size()), 160'(0));
    check("sb_resps_left", 160'(exp_resp.size()), 160'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
